tile_obi_addr_demux: RTL and testbench
======================================

Name: tile_obi_addr_demux

Overview:
- Parametrised OBI address demultiplexer between one core data manager port and N_SBR subordinate ports (HCI/L1 SPM, L2 AXI bridge, ...).
- Decodes each request against a runtime address-rule table.
- Tracks up to N_MAX_TRAN outstanding transactions and routes in-order responses back to the manager.
- Unmapped addresses get an internal error response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; STRB_W = DATA_W/8 derived
N_SBR, 2, number of subordinate ports (>=1)
N_ADDR_RULE, 2, number of address rules (>=1)
N_MAX_TRAN, 4, max outstanding transactions (>=1)
IDX_W, $clog2(N_SBR) (min 1), derived subordinate index width

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
rule_start_i  in  N_ADDR_RULE*ADDR_W  rule start addresses (inclusive)
rule_end_i  in  N_ADDR_RULE*ADDR_W  rule end addresses (exclusive)
rule_idx_i  in  N_ADDR_RULE*IDX_W  target subordinate per rule
mgr_req_i  in  1  manager request
mgr_gnt_o  out  1  manager grant
mgr_addr_i  in  ADDR_W  request address
mgr_we_i  in  1  write enable
mgr_be_i  in  STRB_W  byte enables
mgr_wdata_i  in  DATA_W  write data
mgr_rvalid_o  out  1  response valid
mgr_rdata_o  out  DATA_W  response data
mgr_err_o  out  1  response error
sbr_req_o  out  N_SBR  per-subordinate request
sbr_gnt_i  in  N_SBR  per-subordinate grant
sbr_addr_o  out  ADDR_W  broadcast address
sbr_we_o  out  1  broadcast write enable
sbr_be_o  out  STRB_W  broadcast byte enables
sbr_wdata_o  out  DATA_W  broadcast write data
sbr_rvalid_i  in  N_SBR  per-subordinate response valid
sbr_rdata_i  in  N_SBR*DATA_W  per-subordinate response data
sbr_err_i  in  N_SBR  per-subordinate error

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous, active-low.
- Reset state: cnt=0, last_sel=0, err_pend=0.
- Output values: all outputs are 0 while in reset and whenever they are not driven by the rules below.
- Address decode (combinational):
  - Rule r matches when start_r <= addr < end_r (unsigned compare).
  - The lowest-numbered matching rule wins.
  - A rule with rule_idx >= N_SBR or start >= end never matches.
  - No match gives sel = ERR, a virtual port N_SBR.
- Accept condition `ok`: mgr_req_i & (cnt < N_MAX_TRAN) & (cnt == 0 | sel == last_sel).
  - A request to a different target stalls until all outstanding responses have drained. This preserves response order.
  - When cnt == N_MAX_TRAN the request stalls, even if a response retires in the same cycle (no bypass).
- Request path:
  - sbr_req_o[sel] = ok, and only for a mapped sel.
  - Address, we, be and wdata are broadcast combinationally.
  - mgr_gnt_o = sbr_gnt_i[sel] for mapped sel; 1 for ERR when ok.
  - Zero added request latency.
- Handshake: hs = ok & mgr_gnt_o. On hs: last_sel <= sel, cnt increments.
- ERR target:
  - hs sets err_pend; the next cycle drives mgr_rvalid_o=1, mgr_err_o=1, mgr_rdata_o=0, and err_pend clears.
  - Back-to-back ERR requests complete one per cycle.
- Response path:
  - When last_sel is mapped, mgr_rvalid_o/rdata/err = sbr_rvalid_i/rdata/err of last_sel, gated by cnt != 0.
  - rvalid from any other subordinate is ignored (protocol violation, flagged by assertion).
- Counter:
  - +1 on hs, -1 on a delivered mgr_rvalid_o, unchanged when both happen in the same cycle.
  - Never exceeds N_MAX_TRAN; never underflows (rvalid with cnt=0 is ignored).
- Manager obligations: mgr_* signals stay stable while req is high without gnt (OBI). The block does not latch request fields.
- Rule table: may change only when cnt == 0; otherwise behaviour is undefined.
- Reset mid-operation: in-flight responses are dropped, cnt=0, and no mgr_rvalid_o is issued after reset.

Optional Feature:
- Macro: TILE_OBI_DEMUX_DEFAULT_PORT_EN.
- Defined:
  - Adds parameter DEFAULT_IDX (default 0).
  - Unmapped addresses route to subordinate DEFAULT_IDX like a mapped request.
  - The internal error responder and err_pend are removed; mgr_err_o then reflects only sbr_err_i.
- Undefined: unmapped addresses go to the internal ERR responder as specified above.

Test Plan:
- Rules {0x2000_0000–0x3000_0000→0, 0x1000_0000–0x2000_0000→1}, read 0x1000_0040, sbr1 gnt same cycle, rvalid next cycle with rdata 0xDEAD_BEEF -> sbr_req_o=2'b10; mgr_rvalid_o=1 with rdata 0xDEAD_BEEF, err=0; cnt returns to 0.
- Four back-to-back writes to 0x2000_0000.. with sbr0 rvalid withheld -> 4 grants, 5th request stalls (mgr_gnt_o=0); the first rvalid frees the slot one cycle later.
- Read 0x2000_0000 outstanding, then request to 0x1000_0000 -> stalled until sbr0 rvalid, then granted to sbr1; responses arrive in order.
- Access 0x4000_0000 -> mgr_gnt_o=1 same cycle, next cycle mgr_rvalid_o=1, mgr_err_o=1, rdata=0; no sbr_req_o asserted. With the macro defined and DEFAULT_IDX=0, the request instead goes to sbr0.
- Overlapping rules {0x1000_0000–0x3000_0000→1, 0x2000_0000–0x3000_0000→0}, access 0x2000_0010 -> routed to sbr1 (lowest rule wins). Same-cycle hs and rvalid -> cnt unchanged.
- rst_ni low with cnt=3 -> next cycle cnt=0, all outputs 0; a late sbr_rvalid_i is not forwarded.

Source files
------------

// File: rtl/tile_obi_addr_demux.sv
// OBI address demultiplexer: one manager port to N_SBR subordinates, runtime rule table, in-order responses.
// Define TILE_OBI_DEMUX_DEFAULT_PORT_EN to send unmapped addresses to DEFAULT_IDX instead of the internal error responder.
module tile_obi_addr_demux #(
`ifdef TILE_OBI_DEMUX_DEFAULT_PORT_EN
  parameter int unsigned DEFAULT_IDX = 0,
`endif
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STRB_W      = DATA_W / 8,
  parameter int unsigned N_SBR       = 2,
  parameter int unsigned N_ADDR_RULE = 2,
  parameter int unsigned N_MAX_TRAN  = 4,
  parameter int unsigned IDX_W       = (N_SBR > 1) ? $clog2(N_SBR) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_ADDR_RULE*ADDR_W-1:0] rule_start_i,
  input  logic [N_ADDR_RULE*ADDR_W-1:0] rule_end_i,
  input  logic [N_ADDR_RULE*IDX_W-1:0]  rule_idx_i,
  input  logic                          mgr_req_i,
  output logic                          mgr_gnt_o,
  input  logic [ADDR_W-1:0]             mgr_addr_i,
  input  logic                          mgr_we_i,
  input  logic [STRB_W-1:0]             mgr_be_i,
  input  logic [DATA_W-1:0]             mgr_wdata_i,
  output logic                          mgr_rvalid_o,
  output logic [DATA_W-1:0]             mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic [N_SBR-1:0]              sbr_req_o,
  input  logic [N_SBR-1:0]              sbr_gnt_i,
  output logic [ADDR_W-1:0]             sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [STRB_W-1:0]             sbr_be_o,
  output logic [DATA_W-1:0]             sbr_wdata_o,
  input  logic [N_SBR-1:0]              sbr_rvalid_i,
  input  logic [N_SBR*DATA_W-1:0]       sbr_rdata_i,
  input  logic [N_SBR-1:0]              sbr_err_i
);

  localparam int unsigned SEL_W = $clog2(N_SBR + 1);
  localparam int unsigned CNT_W = $clog2(N_MAX_TRAN + 1);

  logic [SEL_W-1:0]  sel, last_sel_d, last_sel_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              sel_err, hit, ok, gnt_c, hs;
  logic              rvalid_c, rerr_c;
  logic [DATA_W-1:0] rdata_c;
  logic [ADDR_W-1:0] r_start, r_end;
  logic [IDX_W-1:0]  r_idx;
  logic [N_SBR-1:0]  own_mask;

  // Address decode: lowest-numbered valid matching rule wins
  always_comb begin
    hit     = 1'b0;
`ifdef TILE_OBI_DEMUX_DEFAULT_PORT_EN
    sel     = SEL_W'(DEFAULT_IDX);
`else
    sel     = SEL_W'(N_SBR);
`endif
    r_start = '0;
    r_end   = '0;
    r_idx   = '0;
    for (int unsigned r = 0; r < N_ADDR_RULE; r++) begin
      r_start = rule_start_i[r*ADDR_W +: ADDR_W];
      r_end   = rule_end_i[r*ADDR_W +: ADDR_W];
      r_idx   = rule_idx_i[r*IDX_W +: IDX_W];
      if (!hit && (32'(r_idx) < N_SBR) && (r_start < r_end) &&
          (mgr_addr_i >= r_start) && (mgr_addr_i < r_end)) begin
        hit = 1'b1;
        sel = SEL_W'(r_idx);
      end
    end
  end

`ifdef TILE_OBI_DEMUX_DEFAULT_PORT_EN
  assign sel_err = 1'b0;
`else
  assign sel_err = (sel == SEL_W'(N_SBR));
`endif

  // Target switches wait for a full drain so responses stay in order
  assign ok = rst_ni & mgr_req_i & (cnt_q < CNT_W'(N_MAX_TRAN)) &
              ((cnt_q == '0) | (sel == last_sel_q));

  always_comb begin
    sbr_req_o = '0;
    gnt_c     = 1'b0;
    for (int unsigned s = 0; s < N_SBR; s++) begin
      if (sel == SEL_W'(s)) begin
        sbr_req_o[s] = ok;
        gnt_c        = ok & sbr_gnt_i[s];
      end
    end
    if (sel_err) gnt_c = ok;
  end

  assign mgr_gnt_o   = gnt_c;
  assign hs          = ok & gnt_c;
  assign sbr_addr_o  = rst_ni ? mgr_addr_i  : '0;
  assign sbr_we_o    = rst_ni & mgr_we_i;
  assign sbr_be_o    = rst_ni ? mgr_be_i    : '0;
  assign sbr_wdata_o = rst_ni ? mgr_wdata_i : '0;

`ifndef TILE_OBI_DEMUX_DEFAULT_PORT_EN
  logic err_pend_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) err_pend_q <= 1'b0;
    else         err_pend_q <= hs & sel_err;
  end
`endif

  // Response mux follows the target of the outstanding transactions
  always_comb begin
    rvalid_c = 1'b0;
    rdata_c  = '0;
    rerr_c   = 1'b0;
    if (rst_ni && (cnt_q != '0)) begin
`ifndef TILE_OBI_DEMUX_DEFAULT_PORT_EN
      if (last_sel_q == SEL_W'(N_SBR)) begin
        rvalid_c = err_pend_q;
        rerr_c   = err_pend_q;
      end
`endif
      for (int unsigned s = 0; s < N_SBR; s++) begin
        if (last_sel_q == SEL_W'(s)) begin
          rvalid_c = sbr_rvalid_i[s];
          rdata_c  = sbr_rdata_i[s*DATA_W +: DATA_W];
          rerr_c   = sbr_err_i[s];
        end
      end
    end
  end

  assign mgr_rvalid_o = rvalid_c;
  assign mgr_rdata_o  = rdata_c;
  assign mgr_err_o    = rerr_c;

  always_comb begin
    cnt_d      = cnt_q;
    last_sel_d = last_sel_q;
    if (hs) last_sel_d = sel;
    if (hs && !rvalid_c)      cnt_d = cnt_q + CNT_W'(1);
    else if (!hs && rvalid_c) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      last_sel_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      last_sel_q <= last_sel_d;
    end
  end

  // A response from a subordinate other than the active target is a protocol violation
  always_comb begin
    own_mask = '0;
    for (int unsigned s = 0; s < N_SBR; s++) own_mask[s] = (last_sel_q == SEL_W'(s));
  end

  stray_rvalid_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cnt_q != '0) |-> ((sbr_rvalid_i & ~own_mask) == '0));

endmodule

// File: tb/tb_tile_obi_addr_demux.sv
// Directed bench for tile_obi_addr_demux: decode vector table plus multi-cycle sequences.
module tb_tile_obi_addr_demux;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [63:0] rule_start_i, rule_end_i;
  logic [1:0]  rule_idx_i;
  logic        mgr_req_i, mgr_gnt_o, mgr_we_i, mgr_rvalid_o, mgr_err_o;
  logic [31:0] mgr_addr_i, mgr_wdata_i, mgr_rdata_o;
  logic [3:0]  mgr_be_i, sbr_be_o;
  logic [1:0]  sbr_req_o, sbr_gnt_i, sbr_rvalid_i, sbr_err_i;
  logic [31:0] sbr_addr_o, sbr_wdata_o;
  logic        sbr_we_o;
  logic [63:0] sbr_rdata_i;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  tile_obi_addr_demux dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rule_start_i(rule_start_i), .rule_end_i(rule_end_i), .rule_idx_i(rule_idx_i),
    .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
    .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
    .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_err_o(mgr_err_o),
    .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o),
    .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_err_i(sbr_err_i)
  );

  // Rule sets, rule 1 in the upper half
  localparam logic [63:0] RA_S = {32'h1000_0000, 32'h2000_0000};
  localparam logic [63:0] RA_E = {32'h2000_0000, 32'h3000_0000};
  localparam logic [1:0]  RA_I = 2'b10;
  localparam logic [63:0] RB_S = {32'h2000_0000, 32'h1000_0000};
  localparam logic [63:0] RB_E = {32'h3000_0000, 32'h3000_0000};
  localparam logic [1:0]  RB_I = 2'b01;
  localparam logic [63:0] RC_S = {32'h0000_0000, 32'h2000_0000};
  localparam logic [63:0] RC_E = {32'h8000_0000, 32'h2000_0000};
  localparam logic [1:0]  RC_I = 2'b10;
  localparam logic [63:0] RD_S = {32'h1000_0000, 32'h3000_0000};
  localparam logic [63:0] RD_E = {32'h2000_0000, 32'h1000_0000};
  localparam logic [1:0]  RD_I = 2'b10;

  typedef struct {
    logic [63:0] rs;
    logic [63:0] re;
    logic [1:0]  ri;
    logic [31:0] addr;
    logic        we;
    logic [1:0]  gnt;
    logic [1:0]  rv;
    logic [1:0]  serr;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  e_req;
    logic        e_gnt;
    logic        e_rv;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    mgr_req_i = 1'b0; mgr_addr_i = '0; mgr_we_i = 1'b0; mgr_be_i = '0; mgr_wdata_i = '0;
    sbr_gnt_i = '0; sbr_rvalid_i = '0; sbr_rdata_i = '0; sbr_err_i = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic we, input logic [1:0] g);
    mgr_req_i = 1'b1; mgr_addr_i = a; mgr_we_i = we;
    mgr_be_i = we ? 4'hF : 4'h0; mgr_wdata_i = ~a; sbr_gnt_i = g;
  endtask

  task automatic rsp(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] e);
    sbr_rvalid_i = v; sbr_rdata_i = {d1, d0}; sbr_err_i = e;
  endtask

  task automatic rules(input logic [63:0] s, input logic [63:0] e, input logic [1:0] i);
    rule_start_i = s; rule_end_i = e; rule_idx_i = i;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_bad=%0d", n_bad);
    $fatal(1);
  end

  initial begin
    vt[0]  = '{RA_S, RA_E, RA_I, 32'h1000_0040, 1'b0, 2'b10, 2'b10, 2'b00, 32'h1111_1111, 32'hDEAD_BEEF, 2'b10, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vt[1]  = '{RA_S, RA_E, RA_I, 32'h2000_0000, 1'b1, 2'b01, 2'b01, 2'b01, 32'hCAFE_0001, 32'h2222_2222, 2'b01, 1'b1, 1'b1, 1'b1, 32'hCAFE_0001};
    vt[2]  = '{RA_S, RA_E, RA_I, 32'h2FFF_FFFC, 1'b0, 2'b01, 2'b01, 2'b00, 32'h0000_00A5, 32'h3333_3333, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0000_00A5};
    vt[3]  = '{RA_S, RA_E, RA_I, 32'h3000_0000, 1'b1, 2'b11, 2'b00, 2'b00, 32'h4444_4444, 32'h5555_5555, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0};
    vt[4]  = '{RA_S, RA_E, RA_I, 32'h1FFF_FFFF, 1'b0, 2'b10, 2'b10, 2'b10, 32'h6666_6666, 32'h1234_5678, 2'b10, 1'b1, 1'b1, 1'b1, 32'h1234_5678};
    vt[5]  = '{RA_S, RA_E, RA_I, 32'h0FFF_FFFF, 1'b0, 2'b11, 2'b00, 2'b00, 32'h6666_6666, 32'h7777_7777, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0};
    vt[6]  = '{RA_S, RA_E, RA_I, 32'h4000_0000, 1'b0, 2'b11, 2'b00, 2'b00, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0};
    vt[7]  = '{RA_S, RA_E, RA_I, 32'h1000_0000, 1'b0, 2'b00, 2'b10, 2'b10, 32'h7777_7777, 32'h8888_8888, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[8]  = '{RB_S, RB_E, RB_I, 32'h2000_0010, 1'b0, 2'b11, 2'b10, 2'b00, 32'h9999_9999, 32'hABCD_0010, 2'b10, 1'b1, 1'b1, 1'b0, 32'hABCD_0010};
    vt[9]  = '{RC_S, RC_E, RC_I, 32'h2000_0000, 1'b1, 2'b10, 2'b10, 2'b00, 32'hAAAA_AAAA, 32'hBBBB_0001, 2'b10, 1'b1, 1'b1, 1'b0, 32'hBBBB_0001};
    vt[10] = '{RC_S, RC_E, RC_I, 32'h9000_0000, 1'b0, 2'b11, 2'b00, 2'b00, 32'h1, 32'h2, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0};
    vt[11] = '{RD_S, RD_E, RD_I, 32'h2000_0000, 1'b0, 2'b11, 2'b00, 2'b00, 32'h3, 32'h4, 2'b00, 1'b1, 1'b1, 1'b1, 32'h0};
    vt[12] = '{RD_S, RD_E, RD_I, 32'h1800_0000, 1'b0, 2'b10, 2'b10, 2'b00, 32'h5, 32'hCCCC_0002, 2'b10, 1'b1, 1'b1, 1'b0, 32'hCCCC_0002};

    // Reset: outputs held at zero despite active inputs
    idle();
    rst_ni = 1'b0;
    rules(RA_S, RA_E, RA_I);
    req(32'h1000_0040, 1'b1, 2'b11);
    rsp(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11);
    cyc(); cyc();
    #4;
    chk("rst_gnt", 128'(mgr_gnt_o), 128'(0));
    chk("rst_req", 128'(sbr_req_o), 128'(0));
    chk("rst_rsp", {mgr_rvalid_o, mgr_err_o, mgr_rdata_o}, 128'(0));
    chk("rst_bcast", {sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o}, 128'(0));
    cyc();
    idle();
    rst_ni = 1'b1;

    // Decode table: request cycle then response cycle
    for (int i = 0; i < NV; i++) begin
      cyc(); idle();
      rules(vt[i].rs, vt[i].re, vt[i].ri);
      req(vt[i].addr, vt[i].we, vt[i].gnt);
      #4;
      chk($sformatf("v%0d_req", i), 128'(sbr_req_o), 128'(vt[i].e_req));
      chk($sformatf("v%0d_gnt", i), 128'(mgr_gnt_o), 128'(vt[i].e_gnt));
      chk($sformatf("v%0d_bcast", i), {sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o},
          {vt[i].addr, vt[i].we, (vt[i].we ? 4'hF : 4'h0), ~vt[i].addr});
      cyc(); idle();
      rsp(vt[i].rv, vt[i].d0, vt[i].d1, vt[i].serr);
      #4;
      chk($sformatf("v%0d_rvalid", i), 128'(mgr_rvalid_o), 128'(vt[i].e_rv));
      chk($sformatf("v%0d_err", i), 128'(mgr_err_o), 128'(vt[i].e_err));
      chk($sformatf("v%0d_rdata", i), 128'(mgr_rdata_o), 128'(vt[i].e_rdata));
    end

    // Outstanding limit: four grants, fifth stalls even with a same-cycle response
    rules(RA_S, RA_E, RA_I);
    for (int k = 0; k < 4; k++) begin
      cyc(); idle();
      req(32'h2000_0000 + 32'(4 * k), 1'b1, 2'b01);
      #4;
      chk($sformatf("lim_gnt%0d", k), 128'(mgr_gnt_o), 128'(1));
    end
    cyc(); idle();
    req(32'h2000_0010, 1'b1, 2'b01);
    rsp(2'b01, 32'h0000_00A0, 32'h0, 2'b00);
    #4;
    chk("lim_full_gnt", 128'(mgr_gnt_o), 128'(0));
    chk("lim_full_req", 128'(sbr_req_o), 128'(0));
    chk("lim_full_rsp", {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00A0});
    cyc(); idle();
    req(32'h2000_0010, 1'b1, 2'b01);
    #4;
    chk("lim_free_gnt", 128'(mgr_gnt_o), 128'(1));
    for (int k = 0; k < 4; k++) begin
      cyc(); idle();
      rsp(2'b01, 32'h0000_00B0 + 32'(k), 32'h0, 2'b00);
      #4;
      chk($sformatf("lim_drain%0d", k), {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00B0 + 32'(k)});
    end
    cyc(); idle();
    rsp(2'b01, 32'h0000_00BF, 32'h0, 2'b00);
    #4;
    chk("lim_underflow", 128'(mgr_rvalid_o), 128'(0));
    cyc(); idle();
    req(32'h1000_0000, 1'b0, 2'b10);
    #4;
    chk("lim_empty_gnt", {sbr_req_o, mgr_gnt_o}, {2'b10, 1'b1});
    cyc(); idle();
    rsp(2'b10, 32'h0, 32'h0000_00B1, 2'b00);
    #4;
    chk("lim_empty_rsp", {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00B1});

    // Target switch stalls until the earlier response drains
    cyc(); idle();
    req(32'h2000_0000, 1'b0, 2'b01);
    #4;
    chk("sw_first_gnt", 128'(mgr_gnt_o), 128'(1));
    for (int k = 0; k < 2; k++) begin
      cyc(); idle();
      req(32'h1000_0000, 1'b0, 2'b10);
      #4;
      chk($sformatf("sw_stall%0d", k), {sbr_req_o, mgr_gnt_o}, {2'b00, 1'b0});
    end
    cyc(); idle();
    req(32'h1000_0000, 1'b0, 2'b10);
    rsp(2'b01, 32'h0000_00C0, 32'h0000_0BAD, 2'b00);
    #4;
    chk("sw_drain_rsp", {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00C0});
    chk("sw_drain_gnt", 128'(mgr_gnt_o), 128'(0));
    cyc(); idle();
    req(32'h1000_0000, 1'b0, 2'b10);
    #4;
    chk("sw_second_gnt", {sbr_req_o, mgr_gnt_o}, {2'b10, 1'b1});
    cyc(); idle();
    rsp(2'b10, 32'h0000_0BAD, 32'h0000_00C1, 2'b00);
    #4;
    chk("sw_second_rsp", {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00C1});

    // Overlapping rules, same-cycle handshake and response keeps the count
    rules(RB_S, RB_E, RB_I);
    cyc(); idle();
    req(32'h2000_0010, 1'b0, 2'b11);
    #4;
    chk("ov_req", {sbr_req_o, mgr_gnt_o}, {2'b10, 1'b1});
    cyc(); idle();
    req(32'h2000_0010, 1'b0, 2'b10);
    rsp(2'b10, 32'h0, 32'h0000_00D0, 2'b00);
    #4;
    chk("ov_both", {mgr_gnt_o, mgr_rvalid_o, mgr_rdata_o}, {1'b1, 1'b1, 32'h0000_00D0});
    cyc(); idle();
    rsp(2'b10, 32'h0, 32'h0000_00D1, 2'b00);
    #4;
    chk("ov_last", {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00D1});
    cyc(); idle();
    rsp(2'b10, 32'h0, 32'h0000_00D2, 2'b00);
    #4;
    chk("ov_empty", 128'(mgr_rvalid_o), 128'(0));

    // Back-to-back unmapped accesses complete one per cycle
    rules(RA_S, RA_E, RA_I);
    cyc(); idle();
    req(32'h4000_0000, 1'b0, 2'b00);
    sbr_rdata_i = {32'hFFFF_FFFF, 32'hEEEE_EEEE};
    #4;
    chk("err0_req", {sbr_req_o, mgr_gnt_o, mgr_rvalid_o}, {2'b00, 1'b1, 1'b0});
    cyc(); idle();
    req(32'h4000_0004, 1'b0, 2'b00);
    sbr_rdata_i = {32'hFFFF_FFFF, 32'hEEEE_EEEE};
    #4;
    chk("err1_req", {sbr_req_o, mgr_gnt_o}, {2'b00, 1'b1});
    chk("err0_rsp", {mgr_rvalid_o, mgr_err_o, mgr_rdata_o}, {1'b1, 1'b1, 32'h0});
    cyc(); idle();
    #4;
    chk("err1_rsp", {mgr_rvalid_o, mgr_err_o, mgr_rdata_o}, {1'b1, 1'b1, 32'h0});
    cyc(); idle();
    #4;
    chk("err_done", {mgr_rvalid_o, mgr_err_o}, {1'b0, 1'b0});

    // Reset with three outstanding writes drops them
    for (int k = 0; k < 3; k++) begin
      cyc(); idle();
      req(32'h2000_0000, 1'b1, 2'b01);
      #4;
      chk($sformatf("rr_gnt%0d", k), 128'(mgr_gnt_o), 128'(1));
    end
    cyc(); idle();
    rst_ni = 1'b0;
    req(32'h2000_0000, 1'b1, 2'b01);
    rsp(2'b01, 32'h0000_00E0, 32'h0, 2'b01);
    #4;
    chk("rr_outs", {mgr_gnt_o, sbr_req_o, mgr_rvalid_o, mgr_err_o, mgr_rdata_o, sbr_addr_o}, 128'(0));
    cyc(); idle();
    rst_ni = 1'b1;
    rsp(2'b01, 32'h0000_00E1, 32'h0, 2'b01);
    #4;
    chk("rr_late", {mgr_rvalid_o, mgr_err_o, mgr_rdata_o}, 128'(0));
    cyc(); idle();
    req(32'h1000_0000, 1'b0, 2'b10);
    #4;
    chk("rr_after_gnt", {sbr_req_o, mgr_gnt_o}, {2'b10, 1'b1});
    cyc(); idle();
    rsp(2'b10, 32'h0, 32'h0000_00E2, 2'b00);
    #4;
    chk("rr_after_rsp", {mgr_rvalid_o, mgr_rdata_o}, {1'b1, 32'h0000_00E2});

    cyc(); idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
